// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the program-counter unit.
// Imported by pc_next_mux and pc_gen.
package pc_gen_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [31:0] RESETPC_DEF = 32'h8000_0000;
  localparam logic [31:0] ILLOP_DEF   = 32'h8000_0004;
  localparam logic [31:0] XADR_DEF    = 32'h8000_0008;
  localparam int          KBIT_DEF    = 31;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'd0,
    PCSRC_BR  = 2'd1,
    PCSRC_J   = 2'd2,
    PCSRC_JR  = 2'd3
  } pcsrc_e;

endpackage

// File: rtl/pc_next_mux.sv
// Sequential next-PC select with kernel-bit masking.
// Ports: pc, pc_src, branch/jump/jr targets in; pc_plus4, seq_next out.
module pc_next_mux
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int KBIT  = KBIT_DEF
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] branch_tgt,
  input  logic [WIDTH-1:0] jump_tgt,
  input  logic [WIDTH-1:0] jr_tgt,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] seq_next
);

  pcsrc_e           src;
  logic             kernel;
  logic [WIDTH-1:0] tgt;

  assign src      = pcsrc_e'(pc_src);
  assign kernel   = pc[KBIT];
  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    tgt = pc_plus4;
    unique case (src)
      PCSRC_SEQ: tgt = pc_plus4;
      PCSRC_BR:  tgt = branch_tgt;
      PCSRC_J:   tgt = jump_tgt;
      PCSRC_JR:  tgt = jr_tgt;
    endcase
  end

  // User code can never raise privilege; in kernel only jr
  // (and PC+4 wrap) may leave kernel mode.
  always_comb begin
    seq_next = tgt;
    if (!kernel) begin
      seq_next[KBIT] = 1'b0;
    end else if (src == PCSRC_BR || src == PCSRC_J) begin
      seq_next[KBIT] = 1'b1;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter: holds PC/EPC, vectors on illop/irq, kernel bit.
// Ports: clk, reset (async low), pc_wr, pc_src, targets, illop, irq;
//        pc, pc_plus4, epc, kernel, irq_ack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH   = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESETPC = WIDTH'(RESETPC_DEF),
  parameter logic [WIDTH-1:0] ILLOP   = WIDTH'(ILLOP_DEF),
  parameter logic [WIDTH-1:0] XADR    = WIDTH'(XADR_DEF),
  parameter int               KBIT    = KBIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_wr,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] branch_tgt,
  input  logic [WIDTH-1:0] jump_tgt,
  input  logic [WIDTH-1:0] jr_tgt,
  input  logic             illop,
  input  logic             irq,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             kernel,
  output logic             irq_ack
);

  logic [WIDTH-1:0] seq_next;
  logic             irq_pend;
  logic             take_ill;
  logic             take_irq;

  pc_next_mux #(
    .WIDTH (WIDTH),
    .KBIT  (KBIT)
  ) u_mux (
    .pc         (pc),
    .pc_src     (pc_src),
    .branch_tgt (branch_tgt),
    .jump_tgt   (jump_tgt),
    .jr_tgt     (jr_tgt),
    .pc_plus4   (pc_plus4),
    .seq_next   (seq_next)
  );

  assign kernel   = pc[KBIT];
  assign take_ill = pc_wr & illop;
  assign take_irq = pc_wr & ~illop
                  & irq_pend & ~kernel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESETPC;
      epc      <= '0;
      irq_pend <= 1'b0;
      irq_ack  <= 1'b0;
    end else begin
      irq_ack <= take_irq;
      // Pending request follows the level; in kernel it
      // is held but never newly set.
      if (take_irq || !irq) begin
        irq_pend <= 1'b0;
      end else if (!kernel) begin
        irq_pend <= 1'b1;
      end
      if (pc_wr) begin
        unique case (1'b1)
          take_ill: begin
            pc  <= ILLOP;
            epc <= pc_plus4;
          end
          take_irq: begin
            pc  <= XADR;
            epc <= seq_next;
          end
          default: pc <= seq_next;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed spec scenarios then
// random traffic against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] ILV = 32'h8000_0004;
  localparam logic [31:0] XAV = 32'h8000_0008;

  logic        clk;
  logic        reset;
  logic        pc_wr;
  logic [1:0]  pc_src;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic        illop;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        kernel;
  logic        irq_ack;

  pc_gen dut (
    .clk        (clk),
    .reset      (reset),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .branch_tgt (branch_tgt),
    .jump_tgt   (jump_tgt),
    .jr_tgt     (jr_tgt),
    .illop      (illop),
    .irq        (irq),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .epc        (epc),
    .kernel     (kernel),
    .irq_ack    (irq_ack)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ack;
  } exp_t;

  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_pend;
  logic        m_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Monitor: every clock the DUT presents a new state.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mon_pc", pc, e.pc);
      chk("mon_epc", epc, e.epc);
      chk("mon_ack", {31'd0, irq_ack}, {31'd0, e.ack});
      chk("mon_kernel", {31'd0, kernel}, {31'd0, e.pc[31]});
      chk("mon_plus4", pc_plus4, e.pc + 32'd4);
    end
  end

  task automatic model_reset();
    m_pc   = RPC;
    m_epc  = 32'd0;
    m_pend = 1'b0;
    m_ack  = 1'b0;
    q.push_back('{m_pc, m_epc, m_ack});
  endtask

  // Reference: architectural rules applied to the current inputs.
  task automatic model_step();
    logic [31:0] p4, t, s;
    logic        k, ti, tq;
    k  = m_pc[31];
    p4 = m_pc + 32'd4;
    case (pc_src)
      2'd0:    t = p4;
      2'd1:    t = branch_tgt;
      2'd2:    t = jump_tgt;
      default: t = jr_tgt;
    endcase
    if (!k) s = t & 32'h7FFF_FFFF;
    else if (pc_src == 2'd1 || pc_src == 2'd2)
      s = t | 32'h8000_0000;
    else s = t;
    ti = pc_wr && illop;
    tq = pc_wr && !illop && m_pend && !k;
    if (ti) begin
      m_epc = p4;
      m_pc  = ILV;
    end else if (tq) begin
      m_epc = s;
      m_pc  = XAV;
    end else if (pc_wr) begin
      m_pc = s;
    end
    m_ack = tq;
    if (tq || !irq) m_pend = 1'b0;
    else if (!k) m_pend = 1'b1;
    q.push_back('{m_pc, m_epc, m_ack});
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cyc(input logic wr, input logic [1:0] src,
                     input logic [31:0] br, input logic [31:0] j,
                     input logic [31:0] jr, input logic ill,
                     input logic rq);
    pc_wr      = wr;
    pc_src     = src;
    branch_tgt = br;
    jump_tgt   = j;
    jr_tgt     = jr;
    illop      = ill;
    irq        = rq;
    model_step();
    @(negedge clk);
  endtask

  // Async reset away from any clock edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_epc", epc, 32'd0);
    chk("rst_ack", {31'd0, irq_ack}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'd0;
    branch_tgt = '0;
    jump_tgt   = '0;
    jr_tgt     = '0;
    illop      = 1'b0;
    irq        = 1'b0;
    model_reset();
    @(negedge clk);
    model_reset();
    @(negedge clk);
    chk("init_pc", pc, RPC);
    reset = 1'b1;

    // kernel jr to user 0x100, then sequential and stall
    cyc(1, 3, 0, 0, 32'h100, 0, 0);
    chk("jr_user", pc, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("seq3", pc, 32'h10C);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("stall", pc, 32'h10C);

    // user jr cannot set kernel bit
    cyc(1, 3, 0, 0, 32'h100, 0, 0);
    cyc(1, 3, 0, 0, 32'h8000_0200, 0, 0);
    chk("kbit_mask", pc, 32'h200);

    // interrupt taken from user 0x100
    cyc(1, 3, 0, 0, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("irq_pc", pc, XAV);
    chk("irq_epc", epc, 32'h104);
    chk("irq_ack", {31'd0, irq_ack}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("no_2nd_ack", {31'd0, irq_ack}, 32'd0);
    cyc(1, 3, 0, 0, 32'h104, 0, 1);
    chk("eret_pc", pc, 32'h104);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("retaken_pc", pc, XAV);
    chk("retaken_ack", {31'd0, irq_ack}, 32'd1);

    // illop beats pending irq
    cyc(1, 3, 0, 0, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    chk("ill_pc", pc, ILV);
    chk("ill_epc", epc, 32'h44);
    chk("ill_noack", {31'd0, irq_ack}, 32'd0);

    // kernel PC+4 wraps to user 0
    cyc(1, 3, 0, 0, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_k", {31'd0, kernel}, 32'd0);

    // reset mid-stall with irq pending
    cyc(0, 0, 0, 0, 0, 0, 1);
    async_reset();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] b, jt, r;
      logic        w, il, rq;
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        b  = $urandom_range(0, 1) ? ($urandom & 32'hFFC)
                                  : $urandom;
        jt = $urandom_range(0, 1) ? ($urandom & 32'hFFC)
                                  : $urandom;
        r  = $urandom_range(0, 1) ? ($urandom & 32'hFFC)
                                  : $urandom;
        w  = ($urandom_range(0, 4) != 0);
        il = ($urandom_range(0, 15) == 0);
        rq = ($urandom_range(0, 2) == 0);
        cyc(w, 2'($urandom_range(0, 3)), b, jt, r, il, rq);
      end
    end

    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
